fetch_queue: RTL and testbench

Parametrised instruction fetch queue between instruction memory and the decode stage. It generalises decode's single-entry stall buffer into a DEPTH-entry FIFO with credit-based request gating, support for multiple outstanding imem requests, and flush-aware discard of in-flight responses. It sits at the IF/ID boundary: the IF stage issues requests when o_req_ready is high, and decode consumes o_inst/o_pc whenever it is not stalled.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue_storage.sv | 28 ++
 rtl/fetch_queue.sv | 168 ++++++++++++++++
 tb/tb_fetch_queue.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_queue_pkg;

  // addi x0, x0, 0 -- shown to decode whenever there is nothing real to issue
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between IF (imem side), the fetch queue and decode.
interface fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             i_flush;
  logic             i_req_issue;
  logic             o_req_ready;
  logic             imem_resp;
  logic [31:0]      imem_rdata;
  logic [31:0]      i_resp_pc;
  logic             i_deq;
  logic             o_valid;
  logic [31:0]      o_inst;
  logic [31:0]      o_pc;
  logic             o_imem_stall;
  logic [CNT_W-1:0] o_count;

  // Driver side: IF stage, imem and decode together
  modport master (
    output i_flush, i_req_issue, imem_resp, imem_rdata, i_resp_pc, i_deq,
    input  o_req_ready, o_valid, o_inst, o_pc, o_imem_stall, o_count
  );

  // Queue side
  modport slave (
    input  i_flush, i_req_issue, imem_resp, imem_rdata, i_resp_pc, i_deq,
    output o_req_ready, o_valid, o_inst, o_pc, o_imem_stall, o_count
  );
endinterface

// File: rtl/fetch_queue_storage.sv
// DEPTH-entry register file for fetched {inst, pc} pairs: one write port,
// one asynchronous read port. Entries hold data only, so no reset.
module fetch_queue_storage
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  fetch_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output fetch_entry_t rdata
);

  fetch_entry_t mem_q [DEPTH];

  // Write the addressed entry when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue at the IF/ID boundary. Credits gate new imem
// requests, an empty queue bypasses a live response straight to decode, and
// a flush turns every response still in flight into a stale one to discard.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] NOP_INST        = DEFAULT_NOP_INST
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // One spare bit so an out-of-protocol issue does not silently wrap
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1) + 1;
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_SAT   = '1;
  localparam logic [SUM_W-1:0] DEPTH_S   = SUM_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] drop_cnt_q, drop_cnt_d;
  // Responses orphaned by a reset; lets them drain without tripping the
  // unexpected-response check
  logic [OUT_W-1:0] orphan_q, orphan_d;

  logic             resp_ok;
  logic             live;
  logic             empty;
  logic             full;
  logic             deq_fire;
  logic             wr_en;
  logic             overflow;
  logic             unexpected_resp;
  logic [OUT_W:0]   orphan_sum;
  logic [SUM_W-1:0] credit_sum;

  fetch_entry_t     wr_entry;
  fetch_entry_t     head_entry;

  assign wr_entry = '{inst: bus.imem_rdata, pc: bus.i_resp_pc};

  fetch_queue_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (head_entry)
  );

  // Classify this cycle's response and decide what moves in and out
  always_comb begin
    resp_ok         = bus.imem_resp && (outstanding_q != '0);
    live            = resp_ok && (drop_cnt_q == '0) && !bus.i_flush;
    empty           = (count_q == '0);
    full            = (count_q == DEPTH_C);
    deq_fire        = bus.i_deq && !empty && !bus.i_flush;
    // A bypassed-and-consumed response never touches the array
    wr_en           = live && !(empty && bus.i_deq) && (!full || deq_fire);
    overflow        = live && full && !deq_fire;
    unexpected_resp = bus.imem_resp && (outstanding_q == '0) && (orphan_q == '0);
  end

  // Next-state for pointers, occupancy, credits and stale-response tracking
  always_comb begin
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    orphan_d      = orphan_q;
    orphan_sum    = {1'b0, orphan_q} + {1'b0, outstanding_q};

    case ({bus.i_req_issue, resp_ok})
      2'b10:   outstanding_d = (outstanding_q == OUT_SAT) ? outstanding_q
                                                          : outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase

    if (bus.i_flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      // Everything already in flight is pre-redirect; a request issued in
      // this same cycle is post-redirect and must survive
      drop_cnt_d = outstanding_q - OUT_W'(resp_ok);
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(deq_fire);
      if (resp_ok && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - OUT_W'(1);
      end
    end

    if (!rst) begin
      orphan_d = orphan_sum[OUT_W] ? OUT_SAT : orphan_sum[OUT_W-1:0];
    end else if (bus.imem_resp && (outstanding_q == '0) && (orphan_q != '0)) begin
      orphan_d = orphan_q - OUT_W'(1);
    end
  end

  // Control state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
    orphan_q <= orphan_d;
  end

  // Decode-facing outputs; credits look at registers only
  always_comb begin
    credit_sum       = SUM_W'(count_q) + SUM_W'(outstanding_q) - SUM_W'(drop_cnt_q);
    bus.o_req_ready  = (outstanding_q < MAX_OUT_C) && (credit_sum < DEPTH_S);
    bus.o_valid      = !bus.i_flush && (!empty || live);
    bus.o_inst       = NOP_INST;
    bus.o_pc         = '0;
    if (!bus.i_flush) begin
      if (!empty) begin
        bus.o_inst = head_entry.inst;
        bus.o_pc   = head_entry.pc;
      end else if (live) begin
        bus.o_inst = bus.imem_rdata;
        bus.o_pc   = bus.i_resp_pc;
      end
    end
    bus.o_imem_stall = empty && (outstanding_q > drop_cnt_q) && !live;
    bus.o_count      = count_q;
  end

  // Protocol checks: overflowing a full queue, or a response nobody asked for
  always @(posedge clk) begin
    if (rst) begin
      assert (!overflow)
        else $error("fetch_queue: live response while full and not dequeuing, dropped");
      assert (!unexpected_resp)
        else $error("fetch_queue: imem response with no request outstanding");
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, bypass, fill/drain, pointer wrap,
// flush with requests in flight, flush on a response, reset mid-traffic.
module tb_fetch_queue;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(4)) fq_bus ();

  fetch_queue #(
    .DEPTH           (4),
    .MAX_OUTSTANDING (3),
    .NOP_INST        (32'h0000_0013)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (fq_bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    fq_bus.i_flush     = 1'b0;
    fq_bus.i_req_issue = 1'b0;
    fq_bus.imem_resp   = 1'b0;
    fq_bus.imem_rdata  = 32'h0;
    fq_bus.i_resp_pc   = 32'h0;
    fq_bus.i_deq       = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resp(input logic [31:0] inst, input logic [31:0] pc);
    fq_bus.imem_resp  = 1'b1;
    fq_bus.imem_rdata = inst;
    fq_bus.i_resp_pc  = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] pc;

    // ---------------- reset ----------------
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_count", 32'(fq_bus.o_count), 32'd0);
    check("rst_valid", 32'(fq_bus.o_valid), 32'd0);
    check("rst_inst",  fq_bus.o_inst, 32'h0000_0013);
    check("rst_pc",    fq_bus.o_pc, 32'h0);
    check("rst_ready", 32'(fq_bus.o_req_ready), 32'd1);
    check("rst_stall", 32'(fq_bus.o_imem_stall), 32'd0);

    // ---------------- bypass ----------------
    fq_bus.i_req_issue = 1'b1;
    tick();
    idle();
    #1;
    check("byp_wait_stall", 32'(fq_bus.o_imem_stall), 32'd1);
    resp(32'h0050_0093, 32'h1ece_b000);
    fq_bus.i_deq = 1'b1;
    #1;
    check("byp_valid", 32'(fq_bus.o_valid), 32'd1);
    check("byp_inst",  fq_bus.o_inst, 32'h0050_0093);
    check("byp_pc",    fq_bus.o_pc, 32'h1ece_b000);
    check("byp_stall", 32'(fq_bus.o_imem_stall), 32'd0);
    tick();
    idle();
    #1;
    check("byp_count", 32'(fq_bus.o_count), 32'd0);
    check("byp_ready", 32'(fq_bus.o_req_ready), 32'd1);
    check("byp_valid_after", 32'(fq_bus.o_valid), 32'd0);

    // ---------------- fill and backpressure ----------------
    fq_bus.i_req_issue = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      idle();
      pc = 32'h1000 + 32'(4 * i);
      fq_bus.i_req_issue = (i < 3);
      resp(32'hA000_0000 | pc, pc);
      #1;
      // credits before edge: (count,out) = (0,1) (1,1) (2,1) (3,1)
      check($sformatf("fill_ready%0d", i), 32'(fq_bus.o_req_ready), (i < 3) ? 32'd1 : 32'd0);
      tick();
    end
    idle();
    #1;
    check("full_count", 32'(fq_bus.o_count), 32'd4);
    check("full_ready", 32'(fq_bus.o_req_ready), 32'd0);
    check("full_stall", 32'(fq_bus.o_imem_stall), 32'd0);
    check("full_valid", 32'(fq_bus.o_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      pc = 32'h1000 + 32'(4 * i);
      fq_bus.i_deq = 1'b1;
      #1;
      check($sformatf("drain_pc%0d", i), fq_bus.o_pc, pc);
      check($sformatf("drain_inst%0d", i), fq_bus.o_inst, 32'hA000_0000 | pc);
      tick();
      idle();
    end
    #1;
    check("drain_count", 32'(fq_bus.o_count), 32'd0);
    check("drain_valid", 32'(fq_bus.o_valid), 32'd0);
    check("drain_inst",  fq_bus.o_inst, 32'h0000_0013);

    // ---------------- simultaneous enq/deq across the wrap ----------------
    fq_bus.i_req_issue = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      pc = 32'h3000 + 32'(4 * i);
      fq_bus.i_req_issue = 1'b1;
      resp(32'hB000_0000 | pc, pc);
      tick();
    end
    idle();
    fq_bus.i_deq = 1'b1;
    #1;
    check("wrap_pc0", fq_bus.o_pc, 32'h3000);
    tick();
    idle();
    #1;
    check("wrap_count_pre", 32'(fq_bus.o_count), 32'd2);
    fq_bus.i_deq = 1'b1;
    fq_bus.i_req_issue = 1'b1;
    resp(32'hB000_300C, 32'h300C);
    #1;
    check("wrap_pc1", fq_bus.o_pc, 32'h3004);
    tick();
    idle();
    #1;
    check("wrap_count1", 32'(fq_bus.o_count), 32'd2);
    fq_bus.i_deq = 1'b1;
    resp(32'hB000_3010, 32'h3010);
    #1;
    check("wrap_pc2", fq_bus.o_pc, 32'h3008);
    tick();
    idle();
    #1;
    check("wrap_count2", 32'(fq_bus.o_count), 32'd2);
    fq_bus.i_deq = 1'b1;
    #1;
    check("wrap_pc3",   fq_bus.o_pc, 32'h300C);
    check("wrap_inst3", fq_bus.o_inst, 32'hB000_300C);
    tick();
    idle();
    fq_bus.i_deq = 1'b1;
    #1;
    check("wrap_pc4",   fq_bus.o_pc, 32'h3010);
    check("wrap_inst4", fq_bus.o_inst, 32'hB000_3010);
    tick();
    idle();
    #1;
    check("wrap_count_end", 32'(fq_bus.o_count), 32'd0);

    // ---------------- flush with two requests in flight ----------------
    fq_bus.i_req_issue = 1'b1;
    tick();
    tick();
    idle();
    fq_bus.i_flush = 1'b1;
    fq_bus.i_req_issue = 1'b1;
    #1;
    check("fl2_valid", 32'(fq_bus.o_valid), 32'd0);
    check("fl2_inst",  fq_bus.o_inst, 32'h0000_0013);
    tick();
    idle();
    #1;
    // outstanding=3 hits the limit; 3 > drop_cnt=2 so still stalled
    check("fl2_ready", 32'(fq_bus.o_req_ready), 32'd0);
    check("fl2_stall", 32'(fq_bus.o_imem_stall), 32'd1);
    resp(32'hDEAD_0013, 32'h0DEA_D000);
    #1;
    check("fl2_stale1_valid", 32'(fq_bus.o_valid), 32'd0);
    check("fl2_stale1_inst",  fq_bus.o_inst, 32'h0000_0013);
    tick();
    idle();
    resp(32'hDEAD_0113, 32'h0DEA_D004);
    #1;
    check("fl2_stale2_valid", 32'(fq_bus.o_valid), 32'd0);
    tick();
    idle();
    resp(32'h00A0_0113, 32'h2000);
    #1;
    check("fl2_live_valid", 32'(fq_bus.o_valid), 32'd1);
    check("fl2_live_pc",    fq_bus.o_pc, 32'h2000);
    check("fl2_live_inst",  fq_bus.o_inst, 32'h00A0_0113);
    tick();
    idle();
    #1;
    check("fl2_count", 32'(fq_bus.o_count), 32'd1);
    check("fl2_ready_after", 32'(fq_bus.o_req_ready), 32'd1);
    fq_bus.i_deq = 1'b1;
    #1;
    check("fl2_head_pc", fq_bus.o_pc, 32'h2000);
    tick();
    idle();
    #1;
    check("fl2_count_end", 32'(fq_bus.o_count), 32'd0);

    // ---------------- flush coinciding with a response ----------------
    fq_bus.i_req_issue = 1'b1;
    tick();
    idle();
    resp(32'h1111_1111, 32'h4000);
    fq_bus.i_flush = 1'b1;
    fq_bus.i_deq = 1'b1;
    #1;
    check("flr_valid", 32'(fq_bus.o_valid), 32'd0);
    check("flr_inst",  fq_bus.o_inst, 32'h0000_0013);
    tick();
    idle();
    #1;
    check("flr_count", 32'(fq_bus.o_count), 32'd0);
    check("flr_stall", 32'(fq_bus.o_imem_stall), 32'd0);
    check("flr_ready", 32'(fq_bus.o_req_ready), 32'd1);
    fq_bus.i_req_issue = 1'b1;
    tick();
    idle();
    resp(32'h2222_2222, 32'h4004);
    fq_bus.i_deq = 1'b1;
    #1;
    // drop_cnt must be 0, so this response is live
    check("flr_next_valid", 32'(fq_bus.o_valid), 32'd1);
    check("flr_next_pc",    fq_bus.o_pc, 32'h4004);
    tick();
    idle();

    // ---------------- reset mid-traffic ----------------
    fq_bus.i_req_issue = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle();
      pc = 32'h5000 + 32'(4 * i);
      fq_bus.i_req_issue = 1'b1;
      resp(32'hC000_0000 | pc, pc);
      tick();
    end
    idle();
    #1;
    check("mid_count_pre", 32'(fq_bus.o_count), 32'd3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_count", 32'(fq_bus.o_count), 32'd0);
    check("mid_valid", 32'(fq_bus.o_valid), 32'd0);
    check("mid_inst",  fq_bus.o_inst, 32'h0000_0013);
    check("mid_ready", 32'(fq_bus.o_req_ready), 32'd1);
    check("mid_stall", 32'(fq_bus.o_imem_stall), 32'd0);
    resp(32'hC000_5010, 32'h5010);
    #1;
    check("mid_late_valid", 32'(fq_bus.o_valid), 32'd0);
    check("mid_late_inst",  fq_bus.o_inst, 32'h0000_0013);
    tick();
    idle();
    #1;
    check("mid_late_count", 32'(fq_bus.o_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
